sync_r2w_level: RTL

Parametrised successor to the two-flop read-to-write pointer synchroniser. Carries the Gray-coded read pointer of an asynchronous FIFO into the write clock domain through a configurable number of flop stages. Converts the synchronised pointer to binary, computes the registered write-side fill level and full/almost-full flags, and tracks synchroniser warm-up. Sits in the write domain of the async FIFO, between the read-pointer generator and the write-pointer/full logic.

---
 rtl/sync_r2w_level.sv | 90 +++++++++
 1 files changed

// File: rtl/sync_r2w_level.sv
// Read-to-write Gray pointer synchroniser with registered write-side fill level and full flags.
// Optional Gray-sequence checking on the synchronised pointer: define SYNC_R2W_GRAY_CHECK_EN.
module sync_r2w_level #(
  parameter int unsigned ADDRSIZE     = 5,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 28
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic [ADDRSIZE:0]   wbin_next,
  output logic [ADDRSIZE:0]   wq_rptr,
  output logic [ADDRSIZE:0]   wq_rbin,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wfull,
  output logic                walmost_full,
  output logic                wq_valid,
  output logic                wgray_err
);

  localparam int unsigned PW    = ADDRSIZE + 1;
  localparam int unsigned DEPTH = 1 << ADDRSIZE;
  localparam int unsigned CW    = $clog2(SYNC_STAGES + 1);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0] warm_cnt;
  logic [PW-1:0] level_c;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rptr;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wq_rptr = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wq_rbin = '0;
    for (int unsigned i = 0; i < PW; i++) wq_rbin[i] = ^(wq_rptr >> i);
  end

  // Modular subtraction absorbs pointer wrap; MSB-only difference yields DEPTH.
  assign level_c = wbin_next - wq_rbin;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wlevel       <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
    end else begin
      wlevel       <= level_c;
      wfull        <= (level_c == PW'(DEPTH));
      walmost_full <= (level_c >= PW'(AFULL_THRESH));
    end
  end

  // Warm-up: valid once every stage holds a value sampled after reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      warm_cnt <= '0;
      wq_valid <= 1'b0;
    end else if (!wq_valid) begin
      warm_cnt <= warm_cnt + 1'b1;
      wq_valid <= (warm_cnt == CW'(SYNC_STAGES - 1));
    end
  end

`ifdef SYNC_R2W_GRAY_CHECK_EN
  logic [PW-1:0] gray_diff_c;

  // The value about to enter the last stage versus the one leaving it.
  assign gray_diff_c = sync_q[SYNC_STAGES-2] ^ wq_rptr;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wgray_err <= 1'b0;
    end else if (wq_valid && ((gray_diff_c & (gray_diff_c - PW'(1))) != '0)) begin
      wgray_err <= 1'b1;
    end
  end
`else
  assign wgray_err = 1'b0;
`endif

endmodule
